fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one 9-bit fifo among NREQ producers. Each cycle it selects at most one requester and drives the fifo's writep/data_in, gated by the fifo's fullp. A granted requester owns the fifo for a burst of up to BURST consecutive beats, which keeps short packets contiguous. Sits directly in front of the fifo write port; the read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
BITSIZE, 9, data width; matches the fifo word width
BURST, 4, maximum consecutive beats per ownership (1..15)
IDXW, 2, owner index width = clog2(NREQ)

Ports:
clk  input  1  clock, all state on posedge
rstp  input  1  synchronous active-high reset
req  input  NREQ  per-requester write request; bit i = requester i
data_in  input  NREQ*BITSIZE  flattened requester data; requester i at [i*BITSIZE +: BITSIZE]
fullp  input  1  fifo full flag (combinational from fifo count)
gnt  output  NREQ  one-hot grant; a beat is accepted in the cycle gnt[i]=1
writep  output  1  to fifo writep; equals |gnt
data_out  output  BITSIZE  to fifo data_in; muxed data of granted requester, 0 when no grant
owner  output  IDXW  current/last owner index
busy  output  1  1 while a burst is in progress (state BUSY)

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rstp), sampled on posedge only. Reset: state=IDLE, rr_ptr=0, owner=0, beats=0. Outputs during and after reset cycle: gnt=0, writep=0, data_out=0, busy=0.
- gnt, writep, data_out are combinational from registered state and the current req/fullp. There is zero-cycle grant latency: the requester advances its data on the cycle it sees gnt.
- gnt is never asserted while fullp=1. There are no writes to a full fifo and no dropped beats.
- IDLE:
  - Search req starting at rr_ptr, wrapping modulo NREQ; winner = first set bit.
  - If a winner exists and fullp=0: gnt[winner]=1, owner<=winner, beats<=1.
    - If BURST==1: stay IDLE, rr_ptr<=winner+1 (mod NREQ).
    - Otherwise: go to BUSY.
  - If fullp=1 or req=0: no grant, state unchanged.
- BUSY:
  - req[owner]=1 and fullp=0: grant owner, beats<=beats+1. If beats+1==BURST, go to IDLE and rr_ptr<=owner+1 (mod NREQ).
  - req[owner]=1 and fullp=1: no grant; hold owner and beats (stall, no timeout).
  - req[owner]=0: release. No grant this cycle (one bubble), go to IDLE, rr_ptr<=owner+1 (mod NREQ). Other requesters are ignored until IDLE.
- Wrap-around: rr_ptr and owner+1 wrap modulo NREQ. For non-power-of-2 NREQ, index NREQ-1 increments to 0.
- Fairness: with all requesters saturating and fullp=0, owners cycle 0,1,2,...,NREQ-1,0 with exactly BURST beats each and a gap of 0 cycles between bursts.
- Reset mid-burst: abandons ownership; the next grant after reset starts search at requester 0.
- beats width: 4 bits; counts 1..BURST.

Decomposition:
- Shared package fifo_pkg holds:
  - BITSIZE=9 and DEPTH=6 constants used by the fifo;
  - a clog2 function;
  - the arbiter state enum (IDLE=1'b0, BUSY=1'b1).
- One natural sub-module: rr_pick, a combinational round-robin priority picker (inputs req, rr_ptr; outputs valid, idx). It is reused later by a read-side scheduler.

Test Plan:
- Reset and single requester:
  - Stimulus: rstp high 2 cycles, then req=0001, data0=0x1A5, 6 cycles, fullp=0.
  - Required: gnt=0001 on cycles 1-4 (writes 0x1A5 x4, busy=1 then 0). Then IDLE re-grants requester 0 from cycle 5 with no bubble, since rr_ptr=1 wraps search to 0.
- All four requesting, fullp=0:
  - Required: grant order 0x4, 1x4, 2x4, 3x4, 0..., with writep=1 every cycle and owner following the same order.
- fullp stall mid-burst:
  - Stimulus: requester 2 owns with beats=2, then fullp=1 for 3 cycles.
  - Required: gnt=0 and writep=0 for those 3 cycles, owner=2 held. After fullp=0, exactly 2 more beats, then ownership passes to requester 3.
- Early release:
  - Stimulus: requester 1 drops req after 2 beats while requesters 0 and 3 request.
  - Required: one bubble cycle, then requester 3 is granted (rr_ptr=2 search skips 2, finds 3).
- Reset mid-burst:
  - Stimulus: rstp=1 for 1 cycle during requester 3's beat 2, with req=1111.
  - Required: gnt=0 in the reset cycle; the next grant goes to requester 0 with a fresh 4-beat burst.
- Full at IDLE:
  - Stimulus: fullp=1 with req=1111 for 5 cycles.
  - Required: gnt stays 0 and rr_ptr is unchanged. When fullp drops, the first grant goes to the requester at rr_ptr.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, helper function and arbiter state type for the fifo
// and its write-side arbiter.
package fifo_pkg;

  localparam int unsigned BITSIZE = 9;
  localparam int unsigned DEPTH   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo NREQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  int              s;
  logic [IDXW-1:0] j;

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    s     = 0;
    j     = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= int'(NREQ)) s = s - int'(NREQ);
      j = IDXW'(s);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NREQ producers.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BITSIZE = fifo_pkg::BITSIZE,
  parameter int unsigned BURST   = 4,
  parameter int unsigned IDXW    = fifo_pkg::clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rstp,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BITSIZE-1:0] data_in,
  input  logic                    fullp,
  output logic [NREQ-1:0]         gnt,
  output logic                    writep,
  output logic [BITSIZE-1:0]      data_out,
  output logic [IDXW-1:0]         owner,
  output logic                    busy
);

  import fifo_pkg::*;

  arb_state_e      state;
  logic [IDXW-1:0] rr_ptr;
  logic [3:0]      beats;
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] sel;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    if (int'(i) == int'(NREQ) - 1) return '0;
    return i + IDXW'(1);
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Zero-latency grant; suppressed while resetting or when the fifo is full.
  always_comb begin
    gnt      = '0;
    data_out = '0;
    sel      = (state == IDLE) ? pick_idx : owner;
    if (!rstp && !fullp) begin
      if (state == IDLE) begin
        if (pick_valid) gnt[pick_idx] = 1'b1;
      end else begin
        if (req[owner]) gnt[owner] = 1'b1;
      end
    end
    writep = |gnt;
    if (writep) data_out = data_in[int'(sel)*BITSIZE +: BITSIZE];
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rstp) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      beats  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !fullp) begin
            owner <= pick_idx;
            beats <= 4'd1;
            if (BURST == 1) rr_ptr <= next_idx(pick_idx);
            else            state  <= BUSY;
          end
        end
        BUSY: begin
          if (req[owner]) begin
            if (!fullp) begin
              beats <= beats + 4'd1;
              if (beats + 4'd1 == 4'(BURST)) begin
                state  <= IDLE;
                rr_ptr <= next_idx(owner);
              end
            end
          end else begin
            // Owner released early: one bubble, then re-arbitrate.
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, BURST=4).
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned BW   = 9;

  logic            clk = 1'b0;
  logic            rstp;
  logic [NREQ-1:0] req;
  logic [NREQ*BW-1:0] data_in;
  logic            fullp;
  logic [NREQ-1:0] gnt;
  logic            writep;
  logic [BW-1:0]   data_out;
  logic [1:0]      owner;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .BITSIZE(9), .BURST(4), .IDXW(2)) dut (
    .clk      (clk),
    .rstp     (rstp),
    .req      (req),
    .data_in  (data_in),
    .fullp    (fullp),
    .gnt      (gnt),
    .writep   (writep),
    .data_out (data_out),
    .owner    (owner),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle and let combinational outputs settle.
  task automatic drive(input logic r, input logic [3:0] q, input logic f);
    @(negedge clk);
    rstp  = r;
    req   = q;
    fullp = f;
    #1;
  endtask

  task automatic beat(input string tag, input logic [3:0] g, input logic [8:0] d);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_writep"}, 32'(writep), 32'(|g));
    chk({tag, "_data"}, 32'(data_out), 32'(d));
  endtask

  initial begin
    int e;
    rstp    = 1'b1;
    req     = '0;
    fullp   = 1'b0;
    data_in = '0;
    for (int i = 0; i < 4; i++) data_in[i*9 +: 9] = 9'(9'h100 + i);
    data_in[8:0] = 9'h1A5;

    // Reset: grant held off even with requests pending.
    drive(1'b1, 4'hF, 1'b0);
    beat("rst0", 4'h0, 9'h000);
    drive(1'b1, 4'h0, 1'b0);
    beat("rst1", 4'h0, 9'h000);
    chk("rst1_busy", 32'(busy), 32'd0);
    chk("rst1_owner", 32'(owner), 32'd0);

    // Single requester: continuous grants, re-grant from IDLE with no bubble.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 4'h1, 1'b0);
      beat("single", 4'h1, 9'h1A5);
      chk("single_busy", 32'(busy), ((k == 0) || (k == 4)) ? 32'd0 : 32'd1);
      chk("single_owner", 32'(owner), 32'd0);
    end
    data_in[8:0] = 9'h100;
    drive(1'b1, 4'h1, 1'b0);
    beat("rst2", 4'h0, 9'h000);

    // All requesting: 4-beat bursts in order 0,1,2,3 with no gaps.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'hF, 1'b0);
      e = (k / 4) % 4;
      beat("rr_all", 4'(1 << e), 9'(9'h100 + e));
      if (k % 4 != 0) chk("rr_owner", 32'(owner), 32'(e));
    end

    // Stall mid-burst: requester 2 at beats=2, fullp for 3 cycles.
    drive(1'b0, 4'h4, 1'b0);
    beat("stall_b1", 4'h4, 9'h102);
    drive(1'b0, 4'h4, 1'b0);
    beat("stall_b2", 4'h4, 9'h102);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'h4, 1'b1);
      beat("stall_full", 4'h0, 9'h000);
      chk("stall_owner", 32'(owner), 32'd2);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    drive(1'b0, 4'hC, 1'b0);
    beat("stall_b3", 4'h4, 9'h102);
    drive(1'b0, 4'hC, 1'b0);
    beat("stall_b4", 4'h4, 9'h102);
    drive(1'b0, 4'hC, 1'b0);
    beat("stall_next", 4'h8, 9'h103);
    chk("stall_next_busy", 32'(busy), 32'd0);

    // Early release by requester 1 after 2 beats; 0 and 3 waiting.
    drive(1'b1, 4'h0, 1'b0);
    beat("rst3", 4'h0, 9'h000);
    drive(1'b0, 4'h2, 1'b0);
    beat("rel_b1", 4'h2, 9'h101);
    drive(1'b0, 4'h2, 1'b0);
    beat("rel_b2", 4'h2, 9'h101);
    drive(1'b0, 4'h9, 1'b0);
    beat("rel_bubble", 4'h0, 9'h000);
    chk("rel_bubble_busy", 32'(busy), 32'd1);
    drive(1'b0, 4'h9, 1'b0);
    beat("rel_next", 4'h8, 9'h103);

    // Reset during requester 3's beat 2, then fresh burst from requester 0.
    drive(1'b1, 4'hF, 1'b0);
    beat("rst_mid", 4'h0, 9'h000);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'hF, 1'b0);
      beat("post_rst", 4'h1, 9'h100);
      if (k == 0) chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Full at IDLE: nothing granted, pointer held at requester 1.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'hF, 1'b1);
      beat("idle_full", 4'h0, 9'h000);
      chk("idle_full_busy", 32'(busy), 32'd0);
    end
    drive(1'b0, 4'hF, 1'b0);
    beat("idle_resume", 4'h2, 9'h101);
    drive(1'b0, 4'hF, 1'b0);
    chk("idle_resume_owner", 32'(owner), 32'd1);
    chk("idle_resume_busy", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
